// File: rtl/if_fetch_stage.sv
// IF stage: PC register, instruction-memory request and IF/ID pipeline register.
// Optional misaligned-fetch trap enabled by defining IF_ALIGN_CHECK_EN.
//
// state  | meaning
// S_REQ  | fetch of pcIF outstanding, imem_req asserted
// S_HOLD | fetched instruction parked in hold_buf while ID is stalled
module if_fetch_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] npc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pcIF,
  output logic [31:0] pcID,
  output logic [31:0] instrID,
  output logic        validID,
  output logic        adelID
);

  typedef enum logic {S_REQ = 1'b0, S_HOLD = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_if_q, pc_if_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] instr_id_q, instr_id_d;
  logic        valid_id_q, valid_id_d;
  logic        adel_id_q, adel_id_d;
  logic [31:0] hold_buf_q, hold_buf_d;
  logic        hold_adel_q, hold_adel_d;
  logic [31:0] npc_sav_q, npc_sav_d;
  logic        npc_sav_v_q, npc_sav_v_d;

  logic        misaligned;
  logic        fetch_done;
  logic [31:0] fetch_data;
  logic [31:0] next_pc;

`ifdef IF_ALIGN_CHECK_EN
  assign misaligned = (state_q == S_REQ) && (pc_if_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // A misaligned fetch never reaches memory; it completes locally as a NOP.
  assign fetch_done = imem_ready | misaligned;
  assign fetch_data = misaligned ? NOP_INSTR : imem_rdata;
  assign next_pc    = npc_sav_v_q ? npc_sav_q : npc;

  assign imem_req  = (state_q == S_REQ) && !misaligned;
  assign imem_addr = pc_if_q;
  assign pcIF      = pc_if_q;
  assign pcID      = pc_id_q;
  assign instrID   = instr_id_q;
  assign validID   = valid_id_q;
  assign adelID    = adel_id_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_REQ;
      pc_if_q     <= PC_RESET;
      pc_id_q     <= 32'h0;
      instr_id_q  <= NOP_INSTR;
      valid_id_q  <= 1'b0;
      adel_id_q   <= 1'b0;
      hold_buf_q  <= 32'h0;
      hold_adel_q <= 1'b0;
      npc_sav_q   <= 32'h0;
      npc_sav_v_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_if_q     <= pc_if_d;
      pc_id_q     <= pc_id_d;
      instr_id_q  <= instr_id_d;
      valid_id_q  <= valid_id_d;
      adel_id_q   <= adel_id_d;
      hold_buf_q  <= hold_buf_d;
      hold_adel_q <= hold_adel_d;
      npc_sav_q   <= npc_sav_d;
      npc_sav_v_q <= npc_sav_v_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_if_d     = pc_if_q;
    pc_id_d     = pc_id_q;
    instr_id_d  = instr_id_q;
    valid_id_d  = valid_id_q;
    adel_id_d   = adel_id_q;
    hold_buf_d  = hold_buf_q;
    hold_adel_d = hold_adel_q;
    npc_sav_d   = npc_sav_q;
    npc_sav_v_d = npc_sav_v_q;
    case (state_q)
      S_REQ: begin
        if (fetch_done) begin
          if (!stall) begin
            pc_id_d     = pc_if_q;
            instr_id_d  = fetch_data;
            valid_id_d  = 1'b1;
            adel_id_d   = misaligned;
            pc_if_d     = next_pc;
            npc_sav_v_d = 1'b0;
          end else begin
            hold_buf_d  = fetch_data;
            hold_adel_d = misaligned;
            state_d     = S_HOLD;
          end
        end else if (!stall) begin
          pc_id_d    = pc_if_q;
          instr_id_d = NOP_INSTR;
          valid_id_d = 1'b0;
          adel_id_d  = 1'b0;
          // Keep the target of the instruction leaving ID; later bubbles must not replace it.
          if (valid_id_q && !npc_sav_v_q) begin
            npc_sav_d   = npc;
            npc_sav_v_d = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          pc_id_d     = pc_if_q;
          instr_id_d  = hold_buf_q;
          valid_id_d  = 1'b1;
          adel_id_d   = hold_adel_q;
          pc_if_d     = next_pc;
          npc_sav_v_d = 1'b0;
          state_d     = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

endmodule
